// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: req/ack bus master feeding the writeback port.
// Decodes access size, aligns store lanes, extends load data, flags faults.
module mem_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_p_out,
  input  logic [31:0] in_sdata,
  input  logic [4:0]  in_rd,
  input  logic        in_wb_en,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_en,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        exc_valid,
  output logic [1:0]  exc_code
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_en_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        exc_q;
  logic [1:0]  code_q;

  logic        mem_op;
  logic        ill;
  logic        mis;
  logic        go;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ldata;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  assign mem_op = in_load | in_store;
  assign ill = (in_load & in_store)
             | (in_load & (in_funct3 == 3'b011 |
                           in_funct3 == 3'b110 |
                           in_funct3 == 3'b111))
             | (in_store & (in_funct3 >= 3'b011));
  assign mis = (in_funct3[1:0] == 2'b01 & in_p_out[0])
             | (in_funct3[1:0] == 2'b10 & |in_p_out[1:0]);
  assign go  = mem_op & ~ill & ~mis;

  always_comb begin
    be_d    = 4'hF;
    wdata_d = in_sdata;
    if (in_store) begin
      unique case (in_funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << in_p_out[1:0];
          wdata_d = {4{in_sdata[7:0]}};
        end
        2'b01: begin
          be_d    = in_p_out[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{in_sdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign lbyte = bus_rdata[{lane_q, 3'b000} +: 8];
  assign lhalf = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    ldata = bus_rdata;
    unique case (1'b1)
      f3_q == 3'b000: ldata = {{24{lbyte[7]}}, lbyte};
      f3_q == 3'b001: ldata = {{16{lhalf[15]}}, lhalf};
      f3_q == 3'b100: ldata = {24'd0, lbyte};
      f3_q == 3'b101: ldata = {16'd0, lhalf};
      default:        ldata = bus_rdata;
    endcase
  end

  // In BUS the last wait cycle releases stall so upstream moves on the abort edge
  assign stall = (state_q == BUS) ? (~bus_ack & (cnt_q != TMAX)) : go;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lane_q    <= '0;
      f3_q      <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_en_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      exc_q     <= 1'b0;
      code_q    <= '0;
    end else begin
      exc_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          wb_rd_q <= in_rd;
          if (ill) begin
            wb_en_q <= 1'b0;
            exc_q   <= 1'b1;
            code_q  <= 2'b11;
          end else if (mis) begin
            wb_en_q <= 1'b0;
            exc_q   <= 1'b1;
            code_q  <= 2'b01;
          end else if (mem_op) begin
            state_q <= BUS;
            wb_en_q <= 1'b0;
            req_q   <= 1'b1;
            we_q    <= in_store;
            addr_q  <= {in_p_out[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lane_q  <= in_p_out[1:0];
            f3_q    <= in_funct3;
          end else begin
            wb_data_q <= in_p_out;
            wb_en_q   <= in_wb_en;
          end
        end
        BUS: begin
          wb_en_q <= 1'b0;
          if (bus_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wb_rd_q <= in_rd;
            if (bus_err) begin
              exc_q  <= 1'b1;
              code_q <= 2'b10;
            end else if (!we_q) begin
              wb_data_q <= ldata;
              wb_en_q   <= in_wb_en;
            end
          end else if (cnt_q == TMAX) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            exc_q   <= 1'b1;
            code_q  <= 2'b10;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_en     = wb_en_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign exc_valid = exc_q;
  assign exc_code  = code_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table plus reset and idle-ack sequences.
// Expected values are hand-computed per vector.
module tb_mem_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_p_out, in_sdata;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_en;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;
  logic        exc_valid;
  logic [1:0]  exc_code;

  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_p_out(in_p_out),
    .in_sdata(in_sdata), .in_rd(in_rd),
    .in_wb_en(in_wb_en), .stall(stall),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_err(bus_err), .bus_rdata(bus_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          kind;
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    bit          wben;
    int          dly;
    logic [31:0] rdata;
    bit          err;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    bit          chk_data;
    logic [31:0] e_data;
    bit          e_wben;
    logic [1:0]  e_exc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [1:0] code_m = 2'b00;
  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    bit kind, bit ld, bit st, logic [2:0] f3,
    logic [31:0] addr, logic [31:0] sdata, logic [4:0] rd,
    bit wben, int dly, logic [31:0] rdata, bit err,
    logic [3:0] e_be, logic [31:0] e_wdata, bit chk_data,
    logic [31:0] e_data, bit e_wben, logic [1:0] e_exc);
    vec_t v;
    v.kind = kind; v.ld = ld; v.st = st; v.f3 = f3;
    v.addr = addr; v.sdata = sdata; v.rd = rd;
    v.wben = wben; v.dly = dly; v.rdata = rdata;
    v.err = err; v.e_be = e_be; v.e_wdata = e_wdata;
    v.chk_data = chk_data; v.e_data = e_data;
    v.e_wben = e_wben; v.e_exc = e_exc;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int nreq;
    in_load   = v.ld;
    in_store  = v.st;
    in_funct3 = v.f3;
    in_p_out  = v.addr;
    in_sdata  = v.sdata;
    in_rd     = v.rd;
    in_wb_en  = v.wben;
    #1;
    chk($sformatf("v%0d stall_first", idx), 32'(stall), 32'(v.kind));
    if (!v.kind) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d no_req", idx), 32'(bus_req), 0);
    end else begin
      @(posedge clk); #1;
      nreq = 0;
      chk($sformatf("v%0d req", idx), 32'(bus_req), 1);
      chk($sformatf("v%0d we", idx), 32'(bus_we), 32'(v.st));
      chk($sformatf("v%0d addr", idx), bus_addr,
          {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d be", idx), 32'(bus_be), 32'(v.e_be));
      chk($sformatf("v%0d wdata", idx), bus_wdata, v.e_wdata);
      for (int w = 0; w < v.dly && w < TO - 1; w++) begin
        chk($sformatf("v%0d wait_stall", idx), 32'(stall), 1);
        chk($sformatf("v%0d wait_wben", idx), 32'(wb_en), 0);
        if (bus_req) nreq++;
        @(posedge clk); #1;
      end
      if (v.dly < TO) begin
        bus_ack   = 1'b1;
        bus_err   = v.err;
        bus_rdata = v.rdata;
      end
      #1;
      chk($sformatf("v%0d last_stall", idx), 32'(stall), 0);
      if (bus_req) nreq++;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_err = 1'b0;
      chk($sformatf("v%0d req_drop", idx), 32'(bus_req), 0);
      if (v.dly >= TO)
        chk($sformatf("v%0d req_cycles", idx), nreq, TO);
    end
    if (v.e_exc != 2'b00) code_m = v.e_exc;
    chk($sformatf("v%0d wb_en", idx), 32'(wb_en), 32'(v.e_wben));
    chk($sformatf("v%0d exc_valid", idx), 32'(exc_valid),
        32'(v.e_exc != 2'b00));
    chk($sformatf("v%0d exc_code", idx), 32'(exc_code), 32'(code_m));
    if (v.chk_data) begin
      chk($sformatf("v%0d wb_data", idx), wb_data, v.e_data);
      chk($sformatf("v%0d wb_rd", idx), 32'(wb_rd), 32'(v.rd));
    end
  endtask

  task automatic set_alu(input logic [31:0] p, input logic [4:0] rd);
    in_load = 0; in_store = 0; in_funct3 = 3'b000;
    in_p_out = p; in_sdata = 0; in_rd = rd; in_wb_en = 1;
  endtask

  initial begin
    //      k ld st f3      addr          sdata         rd wb dly rdata         err be       wdata         cd data          we exc
    vecs[0]  = mk(0,0,0,3'b000,32'h1234,     0,            5, 1, 0, 0,            0, 4'h0,    0,            1, 32'h1234,     1, 2'b00);
    vecs[1]  = mk(1,1,0,3'b000,32'h103,      0,            7, 1, 2, 32'h80FFFFFF, 0, 4'hF,    0,            1, 32'hFFFFFF80, 1, 2'b00);
    vecs[2]  = mk(1,0,1,3'b001,32'h22,       32'hABCD1234, 4, 1, 0, 0,            0, 4'b1100, 32'h12341234, 0, 0,            0, 2'b00);
    vecs[3]  = mk(0,1,0,3'b010,32'h6,        0,            6, 1, 0, 0,            0, 4'h0,    0,            0, 0,            0, 2'b01);
    vecs[4]  = mk(1,1,0,3'b101,32'h40,       0,            8, 1,TO, 0,            0, 4'hF,    0,            0, 0,            0, 2'b10);
    vecs[5]  = mk(0,0,0,3'b000,32'hDEAD,     0,            9, 1, 0, 0,            0, 4'h0,    0,            1, 32'hDEAD,     1, 2'b00);
    vecs[6]  = mk(1,1,0,3'b100,32'h101,      0,           10, 1, 1, 32'h123480AB, 0, 4'hF,    0,            1, 32'h00000080, 1, 2'b00);
    vecs[7]  = mk(1,1,0,3'b001,32'h102,      0,           11, 1, 0, 32'h80017FFF, 0, 4'hF,    0,            1, 32'hFFFF8001, 1, 2'b00);
    vecs[8]  = mk(1,1,0,3'b010,32'h10,       0,           12, 1, 0, 32'hCAFEBABE, 1, 4'hF,    0,            0, 0,            0, 2'b10);
    vecs[9]  = mk(0,1,1,3'b000,32'h0,        0,           13, 1, 0, 0,            0, 4'h0,    0,            0, 0,            0, 2'b11);
    vecs[10] = mk(0,1,0,3'b011,32'h0,        0,           14, 1, 0, 0,            0, 4'h0,    0,            0, 0,            0, 2'b11);
    vecs[11] = mk(1,0,1,3'b000,32'h203,      32'h00000055, 15, 1, 1, 0,           0, 4'b1000, 32'h55555555, 0, 0,            0, 2'b00);
    vecs[12] = mk(1,0,1,3'b010,32'h0,        32'h11223344, 16, 1, 0, 0,           0, 4'hF,    32'h11223344, 0, 0,            0, 2'b00);
    vecs[13] = mk(1,1,0,3'b101,32'h42,       0,           17, 1, 3, 32'h80017FFF, 0, 4'hF,    0,            1, 32'h00008001, 1, 2'b00);
    vecs[14] = mk(0,0,1,3'b001,32'h21,       0,           18, 0, 0, 0,            0, 4'h0,    0,            0, 0,            0, 2'b01);
    vecs[15] = mk(0,0,1,3'b100,32'h0,        0,           19, 0, 0, 0,            0, 4'h0,    0,            0, 0,            0, 2'b11);
    vecs[16] = mk(0,0,0,3'b000,32'h5,        0,            0, 0, 0, 0,            0, 4'h0,    0,            1, 32'h5,        0, 2'b00);

    rst = 0;
    bus_ack = 0; bus_err = 0; bus_rdata = 0;
    set_alu(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst wb_data", wb_data, 0);
    chk("rst wb_en", 32'(wb_en), 0);
    chk("rst bus_req", 32'(bus_req), 0);
    chk("rst bus_be", 32'(bus_be), 0);
    chk("rst exc_code", 32'(exc_code), 0);
    rst = 1;

    for (int i = 0; i < 17; i++) run(vecs[i], i);

    // bus_ack in IDLE must be ignored
    set_alu(32'hA5A5, 21);
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_ack stall", 32'(stall), 0);
    @(posedge clk); #1;
    bus_ack = 0;
    chk("idle_ack req", 32'(bus_req), 0);
    chk("idle_ack wb_data", wb_data, 32'hA5A5);
    chk("idle_ack wb_en", 32'(wb_en), 1);

    // reset while a load is outstanding
    in_load = 1; in_store = 0; in_funct3 = 3'b010;
    in_p_out = 32'h80; in_rd = 3; in_wb_en = 1;
    @(posedge clk); #1;
    chk("rbus req", 32'(bus_req), 1);
    rst = 0;
    @(posedge clk); #1;
    set_alu(32'h77, 3);
    code_m = 2'b00;
    chk("rbus req_drop", 32'(bus_req), 0);
    chk("rbus addr", bus_addr, 0);
    chk("rbus wb_en", 32'(wb_en), 0);
    chk("rbus exc_code", 32'(exc_code), 0);
    #1;
    chk("rbus stall", 32'(stall), 0);
    rst = 1;
    @(posedge clk); #1;
    chk("rbus alu wb_data", wb_data, 32'h77);
    chk("rbus alu wb_en", 32'(wb_en), 1);
    chk("rbus alu req", 32'(bus_req), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
